// File: rtl/robo_pkg.sv
// ----------------------------------------------------------------------------
// robo_pkg
// Shared types and constants for the wall-following robot: sequencer state
// encoding, default motion timing and the wall-follower decision codes.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package robo_pkg;

   // Motion sequencer states
   typedef enum logic [2:0] {
      OCIOSO     = 3'd0,
      AVANCANDO  = 3'd1,
      GIRANDO    = 3'd2,
      ASSENTANDO = 3'd3,
      TRAVADO    = 3'd4
   } estado_seq_t;

   // Wall-follower decision FSM states, shared so both FSMs use one definition
   typedef enum logic [1:0] {
      PROCURANDO_MURO   = 2'd0,
      ROTACIONANDO      = 2'd1,
      ACOMPANHANDO_MURO = 2'd2
   } estado_muro_t;

   // Default timing, in clock cycles
   localparam int T_AVANCO_PADRAO   = 8;
   localparam int T_GIRO_PADRAO     = 12;
   localparam int T_ASSENTAR_PADRAO = 2;
   localparam int MAX_GIROS_PADRAO  = 4;

   // Largest of three durations, used to size the shared phase timer
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/robo_sequenciador_if.sv
// ----------------------------------------------------------------------------
// robo_sequenciador_if
// Command handshake and motor/sensor outputs between the decision FSM
// (master) and the motion sequencer (slave).
// Optional macro ROBO_ODOMETRIA_EN adds the passos advance counter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface robo_sequenciador_if;
   logic        cmd_valido;
   logic        cmd_avancar;
   logic        cmd_girar;
   logic        cmd_pronto;
   logic        motor_frente;
   logic        motor_giro;
   logic        amostrar;
   logic        preso;
`ifdef ROBO_ODOMETRIA_EN
   logic [15:0] passos;

   modport master (
      output cmd_valido, cmd_avancar, cmd_girar,
      input  cmd_pronto, motor_frente, motor_giro, amostrar, preso, passos
   );
   modport slave (
      input  cmd_valido, cmd_avancar, cmd_girar,
      output cmd_pronto, motor_frente, motor_giro, amostrar, preso, passos
   );
`else
   modport master (
      output cmd_valido, cmd_avancar, cmd_girar,
      input  cmd_pronto, motor_frente, motor_giro, amostrar, preso
   );
   modport slave (
      input  cmd_valido, cmd_avancar, cmd_girar,
      output cmd_pronto, motor_frente, motor_giro, amostrar, preso
   );
`endif
endinterface

`default_nettype wire

// File: rtl/robo_temporizador.sv
// ----------------------------------------------------------------------------
// robo_temporizador
// Loadable down-counter with terminal-count flag. Loaded on entry to each
// timed phase; counts down and rests at 1, where fim_o marks the last cycle.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module robo_temporizador #(
   parameter int LARGURA = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               carga_i,
   input  logic [LARGURA-1:0] valor_i,
   output logic               fim_o
);

   logic [LARGURA-1:0] contagem_q, contagem_d;

   // Next count: load wins, otherwise decrement until reaching 1
   always_comb begin
      contagem_d = contagem_q;
      if (carga_i) begin
         contagem_d = valor_i;
      end else if (contagem_q > LARGURA'(1)) begin
         contagem_d = contagem_q - LARGURA'(1);
      end
   end

   // Count register, cleared asynchronously
   always_ff @(posedge clock or posedge reset) begin
      if (reset) contagem_q <= '0;
      else       contagem_q <= contagem_d;
   end

   assign fim_o = (contagem_q == LARGURA'(1));

endmodule

`default_nettype wire

// File: rtl/robo_sequenciador.sv
// ----------------------------------------------------------------------------
// robo_sequenciador
// Motion sequencer: accepts one advance/rotate command at a time, holds the
// matching motor for a fixed time, settles, strobes a sensor sample, and
// latches a trapped state after too many rotations without an advance.
// Optional macro ROBO_ODOMETRIA_EN adds the 16-bit passos advance counter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module robo_sequenciador
   import robo_pkg::*;
#(
   parameter int T_AVANCO   = T_AVANCO_PADRAO,
   parameter int T_GIRO     = T_GIRO_PADRAO,
   parameter int T_ASSENTAR = T_ASSENTAR_PADRAO,
   parameter int MAX_GIROS  = MAX_GIROS_PADRAO
) (
   input logic                clock,
   input logic                reset,
   robo_sequenciador_if.slave bus
);

   localparam int TW = $clog2(max3(T_AVANCO, T_GIRO, T_ASSENTAR) + 1);
   localparam int GW = $clog2(MAX_GIROS + 1);

   estado_seq_t   estado_q, estado_d;
   logic [GW-1:0] giros_q, giros_d;
   logic          carga;
   logic [TW-1:0] valor_carga;
   logic          fim;

   robo_temporizador #(.LARGURA(TW)) u_temporizador (
      .clock   (clock),
      .reset   (reset),
      .carga_i (carga),
      .valor_i (valor_carga),
      .fim_o   (fim)
   );

   // Next state, timer loads on every phase entry, rotation bookkeeping
   always_comb begin
      estado_d    = estado_q;
      giros_d     = giros_q;
      carga       = 1'b0;
      valor_carga = '0;
      case (estado_q)
         OCIOSO: begin
            // Rotation wins over advance; a command with neither bit is dropped
            if (bus.cmd_valido) begin
               if (bus.cmd_girar) begin
                  estado_d    = GIRANDO;
                  carga       = 1'b1;
                  valor_carga = TW'(T_GIRO);
               end else if (bus.cmd_avancar) begin
                  estado_d    = AVANCANDO;
                  carga       = 1'b1;
                  valor_carga = TW'(T_AVANCO);
               end
            end
         end
         AVANCANDO: begin
            if (fim) begin
               estado_d    = ASSENTANDO;
               carga       = 1'b1;
               valor_carga = TW'(T_ASSENTAR);
               giros_d     = '0;
            end
         end
         GIRANDO: begin
            if (fim) begin
               giros_d = giros_q + GW'(1);
               if (giros_q == GW'(MAX_GIROS - 1)) begin
                  estado_d = TRAVADO;
               end else begin
                  estado_d    = ASSENTANDO;
                  carga       = 1'b1;
                  valor_carga = TW'(T_ASSENTAR);
               end
            end
         end
         ASSENTANDO: begin
            if (fim) estado_d = OCIOSO;
         end
         TRAVADO: begin
            estado_d = TRAVADO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   // State and rotation counter registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= OCIOSO;
         giros_q  <= '0;
      end else begin
         estado_q <= estado_d;
         giros_q  <= giros_d;
      end
   end

   // Outputs decode the registered state only, so reset clears them at once
   assign bus.cmd_pronto   = (estado_q == OCIOSO);
   assign bus.motor_frente = (estado_q == AVANCANDO);
   assign bus.motor_giro   = (estado_q == GIRANDO);
   assign bus.amostrar     = (estado_q == ASSENTANDO) && fim;
   assign bus.preso        = (estado_q == TRAVADO);

`ifdef ROBO_ODOMETRIA_EN
   logic [15:0] passos_q;

   // Completed-advance counter, wraps naturally at 16 bits
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                              passos_q <= '0;
      else if ((estado_q == AVANCANDO) && fim) passos_q <= passos_q + 16'd1;
   end

   assign bus.passos = passos_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_robo_sequenciador.sv
// ----------------------------------------------------------------------------
// tb_robo_sequenciador
// Self-checking bench: directed scenarios plus random commands against a
// queue-based reference of the expected output sequence.
// Optional macro ROBO_ODOMETRIA_EN also checks passos.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_robo_sequenciador;

   localparam int TA = 8;
   localparam int TG = 12;
   localparam int TS = 2;
   localparam int MG = 4;

   // Expected output vector {inc_passos, pronto, frente, giro, amostrar, preso}
   localparam logic [5:0] E_OCIOSO  = 6'b010000;
   localparam logic [5:0] E_FRENTE  = 6'b001000;
   localparam logic [5:0] E_GIRO    = 6'b000100;
   localparam logic [5:0] E_PAUSA   = 6'b000000;
   localparam logic [5:0] E_AMOSTRA = 6'b000010;
   localparam logic [5:0] E_PRESO   = 6'b000001;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   robo_sequenciador_if bus ();

   robo_sequenciador #(
      .T_AVANCO   (TA),
      .T_GIRO     (TG),
      .T_ASSENTAR (TS),
      .MAX_GIROS  (MG)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int         comparados  = 0;
   int         divergentes = 0;
   logic [5:0] fila[$];
   int         giros_mod   = 0;
   bit         preso_mod   = 0;
   int         passos_mod  = 0;

   task automatic verifica(input string tag, input logic [15:0] obs, input logic [15:0] esp);
      comparados++;
      if (obs !== esp) begin
         divergentes++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, esp, $time);
      end
   endtask

   function automatic logic [4:0] observa();
      return {bus.cmd_pronto, bus.motor_frente, bus.motor_giro, bus.amostrar, bus.preso};
   endfunction

   // Settle window: TS-1 quiet cycles then one strobe; inc flags the first
   task automatic empilha_assentar(input bit inc);
      for (int i = 0; i < TS; i++) begin
         logic [5:0] e;
         e = (i == TS - 1) ? E_AMOSTRA : E_PAUSA;
         if (i == 0) e[5] = inc;
         fila.push_back(e);
      end
   endtask

   // One cycle: check the cycle ending now, then present the next inputs
   task automatic ciclo(input bit v, input bit a, input bit g);
      logic [5:0] e;
      bit         ocioso;
      @(negedge clock);
      ocioso = (fila.size() == 0) && !preso_mod;
      if (fila.size() > 0) e = fila.pop_front();
      else                 e = preso_mod ? E_PRESO : E_OCIOSO;
      if (e[5]) passos_mod = (passos_mod + 1) % 65536;
      verifica("saidas", 16'(observa()), 16'(e[4:0]));
`ifdef ROBO_ODOMETRIA_EN
      verifica("passos", bus.passos, 16'(passos_mod));
`endif
      bus.cmd_valido  = v;
      bus.cmd_avancar = a;
      bus.cmd_girar   = g;
      if (v && ocioso) begin
         if (g) begin
            repeat (TG) fila.push_back(E_GIRO);
            giros_mod++;
            if (giros_mod >= MG) preso_mod = 1;
            else                 empilha_assentar(1'b0);
         end else if (a) begin
            repeat (TA) fila.push_back(E_FRENTE);
            giros_mod = 0;
            empilha_assentar(1'b1);
         end
      end
   endtask

   // Full command followed by enough quiet cycles to return to idle
   task automatic comando(input bit a, input bit g);
      ciclo(1'b1, a, g);
      repeat ((g ? TG : TA) + TS) ciclo(1'b0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset mid-cycle; outputs must drop before any clock edge
   task automatic reinicia(input int atraso);
      #(atraso);
      reset = 1'b1;
      #1;
      verifica("reset_assincrono", 16'(observa() & 5'b01111), 16'd0);
      bus.cmd_valido = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      fila.delete();
      giros_mod  = 0;
      preso_mod  = 0;
      passos_mod = 0;
   endtask

   initial begin
      reset           = 1'b1;
      bus.cmd_valido  = 1'b0;
      bus.cmd_avancar = 1'b0;
      bus.cmd_girar   = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Reset state and a single advance
      ciclo(1'b0, 1'b0, 1'b0);
      comando(1'b1, 1'b0);
      repeat (2) ciclo(1'b0, 1'b0, 1'b0);

      // Both bits set: rotation has priority
      comando(1'b1, 1'b1);

      // Four rotations trap; a fifth is ignored; reset clears
      reinicia(2);
      repeat (MG) comando(1'b0, 1'b1);
      ciclo(1'b1, 1'b0, 1'b1);
      repeat (TG + 4) ciclo(1'b0, 1'b0, 1'b0);
      reinicia(3);

      // An advance between rotations clears the count
      repeat (MG - 1) comando(1'b0, 1'b1);
      comando(1'b1, 1'b0);
      repeat (MG - 1) comando(1'b0, 1'b1);
      repeat (3) ciclo(1'b0, 1'b0, 1'b0);

      // Reset in the fifth rotation cycle, then rotations restart from zero
      reinicia(1);
      ciclo(1'b1, 1'b0, 1'b1);
      repeat (5) ciclo(1'b0, 1'b0, 1'b0);
      reinicia(2);
      repeat (MG - 1) comando(1'b0, 1'b1);
      ciclo(1'b0, 1'b0, 1'b0);

      // Command with neither bit is dropped
      ciclo(1'b1, 1'b0, 1'b0);
      repeat (4) ciclo(1'b0, 1'b0, 1'b0);

      // Three advances for the odometer
      repeat (3) comando(1'b1, 1'b0);
      ciclo(1'b0, 1'b0, 1'b0);

      // Random commands with occasional resets
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 249) == 0) begin
            reinicia(int'($urandom_range(1, 3)));
         end else begin
            ciclo($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0);
         end
      end
      ciclo(1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, divergentes);
      $finish;
   end

endmodule

`default_nettype wire
